multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencing controller for the LEGv8 datapath.
- Replaces single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Shares one variable-latency memory port between instruction fetch and data access via a req/ready handshake.
- Drives the same datapath control set (reg2loc, alusrc, mem2reg, aluop, signop, ...) plus per-state write enables.

Parameters:
- MAX_WAIT, 255: maximum cycles any memory access waits for mem_ready before trapping (1..1023).

Ports:
- CLK  input  1  clock, rising edge
- resetl  input  1  asynchronous active-low reset
- opcode  input  11  instruction bits [31:21] from IR; sampled in DECODE
- zero  input  1  ALU zero flag, valid during EXEC
- mem_ready  input  1  memory access complete this cycle
- mem_req  output  1  memory access request; held until mem_ready
- mem_we  output  1  1 = write (STUR)
- mem_sel  output  1  0 = instruction address (PC), 1 = data address (ALU result)
- irwrite  output  1  load IR and latch old PC
- pcwrite  output  1  update PC
- pcsrc  output  1  0 = PC+4, 1 = branch target
- regwrite, reg2loc, alusrc, mem2reg  output  1 each  datapath controls
- aluop  output  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
- signop  output  3  000 I-type, 001 D-type, 010 B, 011 CB, 100 MOVZ
- state_o  output  3  current state encoding
- trap  output  1  sticky illegal-opcode/timeout flag

Behaviour:
- States: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5, S_TRAP=6.
- While resetl=0 (asynchronous): state=S_IDLE, op_q=0, wait counter=0, trap=0. All outputs decode to 0.
- S_IDLE always goes to S_FETCH on the next edge.
- Outputs are combinational from state, op_q, zero, mem_ready. Unlisted outputs are 0 in every state.
- S_FETCH:
  - mem_req=1, mem_sel=0.
  - On mem_ready: irwrite=1, pcwrite=1, pcsrc=0, then go to S_DECODE.
- S_DECODE:
  - op_q <= opcode. Class decode uses the casez opcode patterns: ANDREG ?0001010???, ORRREG ?0101010???, ADDREG ?0?01011???, SUBREG ?1?01011???, ADDIMM ?0?10001???, SUBIMM ?1?10001???, MOVZ 110100101??, B ?00101?????, CBZ ?011010????, LDUR ??111000010, STUR ??111000000.
  - First match in that order wins.
  - Illegal opcode goes to S_TRAP; otherwise go to S_EXEC.
- S_EXEC:
  - aluop, alusrc, reg2loc and signop take the per-instruction values: R-type alusrc=0/reg2loc=0; imm alusrc=1 signop=000; LDUR/STUR alusrc=1 signop=001 aluop=ADD; MOVZ alusrc=1 aluop=0111 signop=100; CBZ reg2loc=1 aluop=0111 signop=011.
  - B: pcwrite=1, pcsrc=1, signop=010; go to S_FETCH.
  - CBZ: pcwrite=zero, pcsrc=1; go to S_FETCH.
  - LDUR/STUR go to S_MEM; all others go to S_WB.
- S_MEM:
  - mem_req=1, mem_sel=1, mem_we=1 for STUR; EXEC ALU controls held.
  - On mem_ready: LDUR goes to S_WB, STUR goes to S_FETCH.
- S_WB:
  - regwrite=1; mem2reg=1 for LDUR, else 0.
  - Go to S_FETCH.
- Wait counter:
  - Clears on entry to S_FETCH/S_MEM and increments each cycle mem_req=1 && mem_ready=0.
  - Reaching MAX_WAIT goes to S_TRAP; mem_req drops on that edge.
- S_TRAP: trap=1 and all enables 0; exit only by reset.
- Reset asserted mid-access immediately forces S_IDLE with mem_req=0. No write enable may be high during reset.
- mem_ready while mem_req=0 is ignored.
- Cycle counts (mem_ready same cycle): ALU/MOVZ=4, LDUR=5, STUR=4, B/CBZ=3.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- When defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle state!=S_IDLE/S_TRAP.
  - instr_cnt increments on each transition into S_FETCH from S_EXEC/S_MEM/S_WB.
  - Both wrap at 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, mem_ready tied 1:
  - State 0→1 next edge.
  - Opcode 10001011000 (ADD reg) gives irwrite/pcwrite pulse in FETCH, aluop=0010 in EXEC, regwrite=1 in WB.
  - Back to FETCH after 4 cycles.
- LDUR (11111000010), mem_ready delayed 3 cycles in MEM:
  - mem_req=1, mem_sel=1, mem_we=0 held 4 cycles.
  - Then WB with mem2reg=1, regwrite=1.
- CBZ (10110100xxx):
  - zero=1 gives pcwrite=1, pcsrc=1 in EXEC.
  - zero=0 gives pcwrite=0.
  - Both return to FETCH with regwrite never asserted.
- STUR (11111000000):
  - mem_we=1 only in MEM.
  - No WB state; regwrite stays 0 throughout.
- Opcode 00000000000 (illegal) gives S_TRAP, trap=1, held 20 cycles.
- MAX_WAIT=4 with mem_ready=0 in FETCH gives trap=1 after 4 wait cycles.
- resetl pulled low during MEM gives immediate mem_req=0, state_o=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared req/ready memory port.
// Optional PERF_COUNTERS_EN adds cycle_cnt / instr_cnt outputs.
module multicycle_control #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcsrc,
  output logic        regwrite,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic [3:0]  aluop,
  output logic [2:0]  signop,
  output logic [2:0]  state_o,
  output logic        trap
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_MOVZ,
    C_B, C_CBZ, C_LDUR, C_STUR, C_ILL
  } cls_e;

  typedef struct packed {
    logic [3:0] aluop;
    logic [2:0] signop;
    logic       alusrc;
    logic       reg2loc;
  } alu_ctrl_t;

  localparam logic [9:0] WAIT_LIM = 10'(MAX_WAIT - 1);

  state_e     state;
  logic [10:0] op_q;
  logic [9:0] wait_cnt;
  cls_e       cls;
  alu_ctrl_t  actl;

  // casez order matters: first matching class wins
  function automatic cls_e decode(input logic [10:0] op);
    casez (op)
      11'b?0001010???: decode = C_AND;
      11'b?0101010???: decode = C_ORR;
      11'b?0?01011???: decode = C_ADD;
      11'b?1?01011???: decode = C_SUB;
      11'b?0?10001???: decode = C_ADDI;
      11'b?1?10001???: decode = C_SUBI;
      11'b110100101??: decode = C_MOVZ;
      11'b?00101?????: decode = C_B;
      11'b?011010????: decode = C_CBZ;
      11'b??111000010: decode = C_LDUR;
      11'b??111000000: decode = C_STUR;
      default:         decode = C_ILL;
    endcase
  endfunction

  assign cls = decode(op_q);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            if (state == S_FETCH)    state <= S_DECODE;
            else if (cls == C_LDUR)  state <= S_WB;
            else                     state <= S_FETCH;
          end else if (wait_cnt == WAIT_LIM) begin
            state <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        S_DECODE: begin
          op_q  <= opcode;
          state <= (decode(opcode) == C_ILL) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            C_B, C_CBZ:     state <= S_FETCH;
            C_LDUR, C_STUR: state <= S_MEM;
            default:        state <= S_WB;
          endcase
        end
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    actl = '0;
    case (cls)
      C_AND:          actl.aluop = 4'b0000;
      C_ORR:          actl.aluop = 4'b0001;
      C_ADD:          actl.aluop = 4'b0010;
      C_SUB:          actl.aluop = 4'b0110;
      C_ADDI:         begin actl.aluop = 4'b0010; actl.alusrc = 1'b1; end
      C_SUBI:         begin actl.aluop = 4'b0110; actl.alusrc = 1'b1; end
      C_LDUR, C_STUR: begin actl.aluop = 4'b0010; actl.alusrc = 1'b1; actl.signop = 3'b001; end
      C_MOVZ:         begin actl.aluop = 4'b0111; actl.alusrc = 1'b1; actl.signop = 3'b100; end
      C_CBZ:          begin actl.aluop = 4'b0111; actl.reg2loc = 1'b1; actl.signop = 3'b011; end
      C_B:            actl.signop = 3'b010;
      default:        actl = '0;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 1'b0;
    regwrite = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    aluop    = 4'b0000;
    signop   = 3'b000;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_EXEC, S_MEM: begin
        aluop   = actl.aluop;
        signop  = actl.signop;
        alusrc  = actl.alusrc;
        reg2loc = actl.reg2loc;
        if (state == S_MEM) begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (cls == C_STUR);
        end else if (cls == C_B) begin
          pcwrite = 1'b1;
          pcsrc   = 1'b1;
        end else if (cls == C_CBZ) begin
          pcwrite = zero;
          pcsrc   = 1'b1;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls == C_LDUR);
      end
      default: ;
    endcase
  end

  assign state_o = state;
  assign trap    = (state == S_TRAP);

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      // retirement = any return to FETCH after the instruction's last state
      if ((state == S_EXEC && (cls == C_B || cls == C_CBZ)) ||
          (state == S_MEM && mem_ready && cls == C_STUR) ||
          state == S_WB)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, built with MAX_WAIT=4 to exercise the timeout quickly.
module tb_multicycle_control;
  logic        CLK = 1'b0;
  logic        resetl;
  logic [10:0] opcode;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, mem_sel, irwrite, pcwrite, pcsrc;
  logic        regwrite, reg2loc, alusrc, mem2reg, trap;
  logic [3:0]  aluop;
  logic [2:0]  signop, state_o;

  int errs = 0, checks = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010100;
  localparam logic [10:0] OP_ILL  = 11'b00000000000;

  multicycle_control #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcsrc(pcsrc), .regwrite(regwrite), .reg2loc(reg2loc),
    .alusrc(alusrc), .mem2reg(mem2reg), .aluop(aluop), .signop(signop),
    .state_o(state_o), .trap(trap)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_en", 32'({irwrite, pcwrite, regwrite, mem_we}), 0);
    tick();
    resetl = 1'b1;
    #1;
  endtask

  initial begin
    resetl = 1'b0; opcode = OP_ADD; zero = 1'b0; mem_ready = 1'b1;
    #2;
    do_reset();
    chk("rst_trap", 32'(trap), 0);
    chk("idle", 32'(state_o), 0);

    // ADD reg: FETCH -> DECODE -> EXEC -> WB -> FETCH
    tick(); chk("add_fetch", 32'(state_o), 1);
    chk("add_fetch_ctl", 32'({mem_req, mem_sel, irwrite, pcwrite, pcsrc}), 32'b10110);
    tick(); chk("add_decode", 32'(state_o), 2);
    tick(); chk("add_exec", 32'(state_o), 3);
    chk("add_aluop", 32'(aluop), 4'b0010);
    chk("add_src", 32'({alusrc, reg2loc, regwrite}), 0);
    tick(); chk("add_wb", 32'(state_o), 5);
    chk("add_wb_ctl", 32'({regwrite, mem2reg}), 2'b10);
    tick(); chk("add_back", 32'(state_o), 1);

    // LDUR with three not-ready cycles in MEM
    opcode = OP_LDUR;
    tick(); tick();
    chk("ldur_exec", 32'({aluop, signop, alusrc}), {4'b0010, 3'b001, 1'b1});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ldur_mem_wait", 32'({state_o, mem_req, mem_sel, mem_we}), {3'd4, 3'b110});
    end
    mem_ready = 1'b1; #1;
    chk("ldur_mem_rdy", 32'({state_o, mem_req, mem_sel, mem_we}), {3'd4, 3'b110});
    tick(); chk("ldur_wb", 32'({state_o, regwrite, mem2reg}), {3'd5, 2'b11});
    tick(); chk("ldur_back", 32'(state_o), 1);

    // CBZ taken then not taken
    for (int z = 1; z >= 0; z--) begin
      opcode = OP_CBZ; zero = 1'b0;
      tick(); tick();
      zero = z[0]; #1;
      chk("cbz_exec", 32'({state_o, pcwrite, pcsrc, regwrite}), {3'd3, z[0], 2'b10});
      chk("cbz_alu", 32'({aluop, signop, reg2loc, alusrc}), {4'b0111, 3'b011, 2'b10});
      tick(); chk("cbz_back", 32'({state_o, regwrite}), {3'd1, 1'b0});
    end
    zero = 1'b0;

    // STUR: write only in MEM, no WB
    opcode = OP_STUR;
    chk("stur_fetch_we", 32'(mem_we), 0);
    tick(); tick();
    chk("stur_exec", 32'({mem_we, regwrite, alusrc}), 3'b001);
    tick(); chk("stur_mem", 32'({state_o, mem_req, mem_sel, mem_we, regwrite}), {3'd4, 4'b1110});
    tick(); chk("stur_back", 32'({state_o, regwrite}), {3'd1, 1'b0});

    // B: 3-cycle branch
    opcode = OP_B;
    tick(); tick();
    chk("b_exec", 32'({pcwrite, pcsrc, signop}), {2'b11, 3'b010});
    tick(); chk("b_back", 32'(state_o), 1);

    // MOVZ
    opcode = OP_MOVZ;
    tick(); tick();
    chk("movz_exec", 32'({aluop, signop, alusrc}), {4'b0111, 3'b100, 1'b1});
    tick(); chk("movz_wb", 32'(regwrite), 1);
    tick();

    // illegal opcode traps and stays
    opcode = OP_ILL;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      chk("ill_trap", 32'({state_o, trap, mem_req, pcwrite, regwrite}), {3'd6, 4'b1000});
      tick();
    end

    // fetch timeout with MAX_WAIT=4
    do_reset();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("to_wait", 32'({state_o, trap}), {3'd1, 1'b0});
      tick();
    end
    chk("to_last", 32'({state_o, mem_req}), {3'd1, 1'b1});
    tick();
    chk("to_trap", 32'({state_o, trap, mem_req}), {3'd6, 2'b10});

    // reset in the middle of a MEM access
    mem_ready = 1'b1;
    do_reset();
    opcode = OP_LDUR;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); chk("mid_mem", 32'({state_o, mem_req}), {3'd4, 1'b1});
    resetl = 1'b0; #1;
    chk("mid_rst", 32'({state_o, mem_req, regwrite, irwrite, pcwrite}), 0);
    tick();
    resetl = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
